servo_motion_sequencer: RTL and testbench
=========================================

# servo_motion_sequencer

- Sits between the command source (host/UART decoder) and the per-joint servo PWM generators of the robotic arm.
- Accepts target-angle commands per joint over a valid/ready handshake and slews each joint's output angle toward its target by at most `STEP` degrees per 20 ms servo frame.
- Publishes all joint angles atomically once per frame, so no PWM generator ever sees a mid-frame angle change.

## Interface

Parameters:
- `NUM_JOINTS`, 4: number of servo joints; legal range 1..8.
- `FRAME_CYCLES`, 1_000_000: clock cycles per servo frame (20 ms @ 50 MHz); must exceed `NUM_JOINTS`+2.
- `STEP`, 2: maximum angle change per joint per frame, in degrees; legal range 1..180.
- `HOME_ANGLE`, 90: reset value of every target and output angle.
- `MAX_ANGLE`, 180: upper legal angle, used by the clamp feature.

Ports:
- `clk`, in, 1: system clock, 50 MHz.
- `reset`, in, 1: synchronous, active-high reset.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: sequencer can accept a command.
- `cmd_joint`, in, JW = max(1, $clog2(NUM_JOINTS)): joint index.
- `cmd_angle`, in, 8: target angle in degrees.
- `halt`, in, 1: freeze motion; commands are still accepted.
- `angle_out`, out, 8*NUM_JOINTS: committed angles; joint j occupies bits [8j+7:8j]; feeds the PWM generators.
- `moving`, out, NUM_JOINTS: bit j = 1 while committed angle j ≠ target j.
- `all_settled`, out, 1: no bit of `moving` is set.
- `frame_tick`, out, 1: one-cycle pulse at each frame boundary.
- `range_err`, out, 1: one-cycle pulse when a command was clamped (macro-dependent; see Configuration).

## Operation

- Frame counter runs 0..FRAME_CYCLES-1 and wraps. `frame_tick` is 1 in the cycle where the count equals FRAME_CYCLES-1.
- Each joint has a target register `tgt[j]`, a working register `cur[j]`, and the committed output `angle_out[j]`.
- FSM states: IDLE, UPDATE, COMMIT.
  - IDLE: `cmd_ready` = 1. On `frame_tick` with `halt` = 0, go to UPDATE with idx = 0. A tick while `halt` = 1 is dropped and the FSM stays in IDLE.
  - UPDATE: `cmd_ready` = 0. Processes joint idx in one cycle:
    - if cur < tgt: cur ← min(cur+STEP, tgt)
    - if cur > tgt: cur ← max(cur−STEP, tgt)
    - else unchanged.
    - Arithmetic is done at 9 bits, so there is no wrap at 255 or below 0.
    - idx increments; after idx = NUM_JOINTS-1, go to COMMIT.
  - COMMIT: `cmd_ready` = 0. All `angle_out[j]` ← `cur[j]` in one cycle, then go to IDLE.
- Command accept = `cmd_valid` & `cmd_ready`. It writes `tgt[cmd_joint]` on that clock edge.
  - `cmd_joint` ≥ NUM_JOINTS: the command is accepted, discarded, and no state changes.
  - Multiple commands to the same joint within one frame: the last accepted one wins.
- A command and `frame_tick` in the same IDLE cycle: the command is written first, and the UPDATE that follows uses the new target.
- `moving[j]` = (`angle_out[j]` ≠ `tgt[j]`), registered. `all_settled` = ~|`moving`.
- A `halt` asserted during UPDATE or COMMIT does not abort; the current sweep completes.

## Timing

- Reset values:
  - `angle_out` all = HOME_ANGLE; `tgt`/`cur` = HOME_ANGLE.
  - `cmd_ready` = 0 in the reset cycle, 1 from the first cycle after reset is released.
  - `moving` = 0, `all_settled` = 1, `frame_tick` = 0, `range_err` = 0.
  - Frame counter = 0, FSM = IDLE.
- Reset asserted mid-UPDATE or mid-COMMIT: everything returns to the reset values on the next edge, and no partial commit becomes visible.
- With the tick in cycle T:
  - UPDATE occupies cycles T+1..T+NUM_JOINTS.
  - COMMIT occupies T+NUM_JOINTS+1.
  - The new `angle_out` is visible from T+NUM_JOINTS+2.
  - `moving` updates one cycle after that.
- Command-to-first-motion latency: up to one frame plus NUM_JOINTS+2 cycles.
- `cmd_ready` is low for exactly NUM_JOINTS+1 cycles per frame, or never in a frame whose tick is dropped by `halt`.
- The command source must hold `cmd_valid` and its data until accepted.
- The first frame tick after reset occurs FRAME_CYCLES cycles after reset is released.

## Configuration

- Macro `SERVO_ANGLE_CLAMP_EN`.
- Defined: on accept, `cmd_angle` > MAX_ANGLE is stored as MAX_ANGLE, and `range_err` pulses 1 cycle after the accept edge.
- Undefined: `cmd_angle` is stored unmodified (values up to 255 are passed on to the PWM generators), and `range_err` is tied to 0.

## Test plan

- Reset release, no commands: `angle_out` = {90,90,90,90} and `all_settled` = 1 for 3 frames; `cmd_ready` = 1 from the first cycle after reset is released.
- Command joint 1 → 100 (STEP = 2): `angle_out[1]` takes 92, 94, …, 100 on 5 successive commits; `moving[1]` = 1 until the commit that outputs 100; the other joints stay at 90.
- Command joint 0 → 89 (odd distance from 90, STEP = 2): `angle_out[0]` = 89 after the first commit, with no overshoot to 88.
- Hold `cmd_valid` across a tick (joint 2 → 0): accepted only in IDLE; during the NUM_JOINTS+1 busy cycles `cmd_ready` = 0 and `tgt` is unchanged; all joints' `angle_out` change in the same cycle.
- `halt` = 1 for 2 frames while moving: `angle_out` is frozen and `frame_tick` still pulses; after `halt` is released, ramping resumes from the frozen value.
- `cmd_angle` = 200:
  - with `SERVO_ANGLE_CLAMP_EN`, target = 180 and `range_err` pulses once;
  - without it, the ramp ends at 200 and `range_err` stays 0.
  - Separately, `cmd_joint` = 5 with NUM_JOINTS = 4 is accepted and ignored.

Source files
------------

// File: rtl/servo_motion_sequencer.sv
// Per-joint target slewing with once-per-frame atomic commit of all angles.
// Optional input clamp: define SERVO_ANGLE_CLAMP_EN.
module servo_motion_sequencer #(
  parameter int NUM_JOINTS   = 4,
  parameter int FRAME_CYCLES = 1_000_000,
  parameter int STEP         = 2,
  parameter int HOME_ANGLE   = 90,
  parameter int MAX_ANGLE    = 180,
  localparam int JW = (NUM_JOINTS > 1) ? $clog2(NUM_JOINTS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [JW-1:0]           cmd_joint,
  input  logic [7:0]              cmd_angle,
  input  logic                    halt,
  output logic [8*NUM_JOINTS-1:0] angle_out,
  output logic [NUM_JOINTS-1:0]   moving,
  output logic                    all_settled,
  output logic                    frame_tick,
  output logic                    range_err
);

  localparam int CW = $clog2(FRAME_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);
  localparam logic [JW-1:0] IDX_LAST = JW'(NUM_JOINTS - 1);
  localparam logic [7:0] HOME = 8'(HOME_ANGLE);
  localparam logic [8:0] STEP9 = 9'(STEP);

  if (NUM_JOINTS < 1 || NUM_JOINTS > 8 || STEP < 1 || STEP > 180 ||
      MAX_ANGLE > 255 || FRAME_CYCLES <= NUM_JOINTS + 2) begin : g_bad
    $error("servo_motion_sequencer: illegal parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    COMMIT
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic [JW-1:0] idx;
  logic [7:0] tgt [NUM_JOINTS];
  logic [7:0] cur [NUM_JOINTS];
  logic [7:0] com [NUM_JOINTS];
  logic [NUM_JOINTS-1:0] moving_q;
  logic range_q;
  logic tick;
  logic accept;
  logic jok;
  logic [7:0] wr_angle;
  logic clamp_hit;
  logic [8:0] c9, t9;
  logic [7:0] cur_nx;

  assign tick = (cnt == LAST);
  assign frame_tick = tick & ~reset;
  assign cmd_ready = (state == IDLE) & ~reset;
  assign accept = cmd_valid & cmd_ready;
  assign jok = int'(cmd_joint) < NUM_JOINTS;

`ifdef SERVO_ANGLE_CLAMP_EN
  assign clamp_hit = cmd_angle > 8'(MAX_ANGLE);
  assign wr_angle = clamp_hit ? 8'(MAX_ANGLE) : cmd_angle;
`else
  assign clamp_hit = 1'b0;
  assign wr_angle = cmd_angle;
`endif

  assign range_err = range_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (tick && !halt) state_nx = UPDATE;
      UPDATE:  if (idx == IDX_LAST) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // 9-bit compare keeps the slew from wrapping near 0 or 255
  always_comb begin
    c9 = {1'b0, cur[idx]};
    t9 = {1'b0, tgt[idx]};
    cur_nx = cur[idx];
    if (c9 < t9) begin
      cur_nx = (t9 > c9 + STEP9) ? 8'(c9 + STEP9) : tgt[idx];
    end else if (c9 > t9) begin
      cur_nx = (c9 > t9 + STEP9) ? 8'(c9 - STEP9) : tgt[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      range_q  <= 1'b0;
      moving_q <= '0;
      for (int j = 0; j < NUM_JOINTS; j++) begin
        tgt[j] <= HOME;
        cur[j] <= HOME;
        com[j] <= HOME;
      end
    end else begin
      state   <= state_nx;
      cnt     <= tick ? '0 : cnt + 1'b1;
      range_q <= accept & jok & clamp_hit;
      if (accept && jok) tgt[cmd_joint] <= wr_angle;
      if (state == UPDATE) begin
        cur[idx] <= cur_nx;
        idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      if (state == COMMIT) begin
        for (int j = 0; j < NUM_JOINTS; j++) com[j] <= cur[j];
      end
      for (int j = 0; j < NUM_JOINTS; j++) begin
        moving_q[j] <= (com[j] != tgt[j]);
      end
    end
  end

  for (genvar j = 0; j < NUM_JOINTS; j++) begin : g_out
    assign angle_out[8*j +: 8] = com[j];
  end

  assign moving = moving_q;
  assign all_settled = ~|moving_q;

endmodule

// File: tb/tb_servo_motion_sequencer.sv
// Directed bench for servo_motion_sequencer (5 joints, 20-cycle frames).
// Expectations track SERVO_ANGLE_CLAMP_EN when the bench is built with it.
module tb_servo_motion_sequencer;

  localparam int N  = 5;
  localparam int FC = 20;
  localparam int JW = 3;
`ifdef SERVO_ANGLE_CLAMP_EN
  localparam int CLAMP = 1;
`else
  localparam int CLAMP = 0;
`endif
  localparam int FINAL1 = CLAMP ? 180 : 200;

  logic clk = 1'b0;
  logic reset;
  logic cmd_valid;
  logic cmd_ready;
  logic [JW-1:0] cmd_joint;
  logic [7:0] cmd_angle;
  logic halt;
  logic [8*N-1:0] angle_out;
  logic [N-1:0] moving;
  logic all_settled;
  logic frame_tick;
  logic range_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_tick = -1;
  logic [8*N-1:0] home;
  logic [8*N-1:0] snap;

  servo_motion_sequencer #(
    .NUM_JOINTS(N), .FRAME_CYCLES(FC), .STEP(2),
    .HOME_ANGLE(90), .MAX_ANGLE(180)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_joint(cmd_joint), .cmd_angle(cmd_angle),
    .halt(halt), .angle_out(angle_out),
    .moving(moving), .all_settled(all_settled),
    .frame_tick(frame_tick), .range_err(range_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int ang(input int j);
    return int'(angle_out[8*j +: 8]);
  endfunction

  task automatic wait_tick();
    int n = 0;
    while (frame_tick !== 1'b1 && n < 3 * FC) begin
      @(negedge clk);
      n++;
    end
    chk("tick_seen", frame_tick, 1);
    if (last_tick >= 0) chk("tick_period", (cyc - last_tick) % FC, 0);
    last_tick = cyc;
  endtask

  task automatic run_frame(input int busy_exp);
    int busy = 0;
    wait_tick();
    for (int i = 0; i < N + 1; i++) begin
      @(negedge clk);
      if (!cmd_ready) busy++;
    end
    @(negedge clk);
    chk("busy_cycles", busy, busy_exp);
  endtask

  task automatic send(input int j, input int a);
    int n = 0;
    cmd_joint = JW'(j);
    cmd_angle = 8'(a);
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 3 * FC) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int busy;
    int stable;
    int mv;
    home = {N{8'd90}};
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_joint = '0;
    cmd_angle = '0;
    halt = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_angle", angle_out, home);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_moving", moving, 0);
    chk("rst_settled", all_settled, 1);
    chk("rst_tick", frame_tick, 0);
    chk("rst_rerr", range_err, 0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", cmd_ready, 1);

    for (int f = 0; f < 3; f++) begin
      run_frame(N + 1);
      chk("idle_angle", angle_out, home);
      chk("idle_settled", all_settled, 1);
    end

    send(1, 100);
    @(negedge clk);
    chk("mov1_pre", moving[1], 1);
    for (int k = 0; k < 5; k++) begin
      run_frame(N + 1);
      chk("ramp_a1", ang(1), 92 + 2 * k);
      chk("ramp_a0", ang(0), 90);
      chk("ramp_a2", ang(2), 90);
      @(negedge clk);
      chk("ramp_mov1", moving[1], (k < 4) ? 1 : 0);
    end

    send(0, 89);
    run_frame(N + 1);
    chk("odd_a0", ang(0), 89);
    @(negedge clk);
    chk("odd_mov0", moving[0], 0);
    run_frame(N + 1);
    chk("odd_hold", ang(0), 89);

    send(3, 96);
    send(4, 84);
    wait_tick();
    snap = angle_out;
    @(negedge clk);
    cmd_joint = 3'd2;
    cmd_angle = 8'd0;
    cmd_valid = 1'b1;
    busy = 0;
    stable = 1;
    mv = 0;
    for (int i = 0; i < N + 1; i++) begin
      if (!cmd_ready) busy++;
      if (angle_out !== snap) stable = 0;
      if (moving[2]) mv = 1;
      @(negedge clk);
    end
    chk("hold_busy", busy, N + 1);
    chk("hold_stable", stable, 1);
    chk("hold_tgt", mv, 0);
    chk("hold_mov2", moving[2], 0);
    chk("hold_ready", cmd_ready, 1);
    chk("atom_a3", ang(3), 92);
    chk("atom_a4", ang(4), 88);
    chk("atom_a1", ang(1), 100);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("hold_accept", moving[2], 1);

    halt = 1'b1;
    snap = angle_out;
    for (int f = 0; f < 2; f++) begin
      run_frame(0);
      chk("halt_frozen", angle_out, snap);
    end
    halt = 1'b0;
    run_frame(N + 1);
    chk("resume_a2", ang(2), 88);
    chk("resume_a3", ang(3), 94);
    chk("resume_a4", ang(4), 86);
    run_frame(N + 1);
    chk("resume2_a2", ang(2), 86);
    chk("resume2_a3", ang(3), 96);
    chk("resume2_a4", ang(4), 84);

    send(1, 200);
    chk("rerr_pulse", range_err, CLAMP);
    @(negedge clk);
    chk("rerr_end", range_err, 0);
    for (int f = 0; f < 55; f++) run_frame(N + 1);
    chk("big_a1", ang(1), FINAL1);
    chk("floor_a2", ang(2), 0);
    @(negedge clk);
    chk("big_settled", all_settled, 1);

    send(5, 250);
    chk("bad_joint_rerr", range_err, 0);
    snap = angle_out;
    run_frame(N + 1);
    chk("bad_joint_angle", angle_out, snap);
    @(negedge clk);
    chk("bad_joint_settled", all_settled, 1);

    send(0, 120);
    wait_tick();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_angle", angle_out, home);
    chk("midrst_ready", cmd_ready, 0);
    chk("midrst_moving", moving, 0);
    reset = 1'b0;
    last_tick = -1;
    #1;
    chk("midrst_ready1", cmd_ready, 1);
    run_frame(N + 1);
    chk("midrst_home", angle_out, home);
    chk("midrst_settled", all_settled, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
